// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Brings the system PLL out of reset and waits for it to lock. Once lock has
// held steadily for a set time, it releases the per-domain resets one at a
// time in a fixed order. If lock is lost or the user asks for a reset, it
// starts again. If the PLL does not lock within the timeout, it retries.
//
// The block runs only on refclk, because the PLL output clocks cannot be
// used until lock. pll_locked_i is asynchronous to refclk, so it passes
// through a two-flop synchronizer. Each consuming clock domain
// resynchronises its own domain_rst_o bit.
//
// Optional feature (off by default):
//   PLL_SEQ_LOCK_DEBOUNCE_EN - in RELEASE and RUN, lock loss counts only after
//   lock_s has been low for 4 consecutive cycles. Shorter glitches are
//   ignored and the stagger count keeps running.
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
    parameter int unsigned NUM_DOMAINS         = 4,
    parameter int unsigned STAGGER_CYCLES      = 8
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked_i,
    input  logic                   sw_reset_i,
    output logic                   pll_rst_o,
    output logic [NUM_DOMAINS-1:0] domain_rst_o,
    output logic                   ready_o,
    output logic [7:0]             retry_count_o,
    output logic [2:0]             state_o
);

    // ------------------------------------------------------------------------
    // Counter sizing. One shared counter serves every timed state. It must
    // hold the largest terminal value without wrapping.
    // ------------------------------------------------------------------------
    localparam int unsigned REL_SPAN  = NUM_DOMAINS * STAGGER_CYCLES;
    localparam int unsigned MAX_AB    = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                        PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_CD    = (LOCK_STABLE_CYCLES > REL_SPAN) ?
                                        LOCK_STABLE_CYCLES : REL_SPAN;
    localparam int unsigned CNT_MAX   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PLL_RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST  = CNT_W'((NUM_DOMAINS - 1) * STAGGER_CYCLES);

    // The state encodings are visible on state_o for debug, so they are fixed.
    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             retry_q, retry_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
    logic                   ready_q, ready_d;

    logic                   lock_meta_q, lock_meta_d;
    logic                   lock_sync_q, lock_sync_d;
    logic                   lock_s;
    logic                   lock_lost;

    assign lock_s = lock_sync_q;

    // Two-flop synchronizer path for the asynchronous PLL locked signal.
    always_comb begin
        lock_meta_d = pll_locked_i;
        lock_sync_d = lock_meta_q;
    end

    // Synchronizer flops. They clear on reset, so the block starts out seeing "not locked".
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment, so
            // every flop samples values from before the edge. Blocking
            // assignment here would turn this two-flop chain into a single flop.
            lock_meta_q <= lock_meta_d;
            lock_sync_q <= lock_sync_d;
        end
    end

`ifdef PLL_SEQ_LOCK_DEBOUNCE_EN
    logic [1:0] deb_q, deb_d;

    // Count consecutive low lock_s cycles while in RELEASE/RUN. A high cycle, a user reset or another state clears the count.
    always_comb begin
        deb_d = '0;
        if (!lock_s && !sw_reset_i &&
            (state_q == ST_RELEASE || state_q == ST_RUN) && deb_q != 2'd3) begin
            deb_d = deb_q + 2'd1;
        end
    end

    // Debounce counter register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            deb_q <= '0;
        end else begin
            deb_q <= deb_d;
        end
    end

    // Lock loss counts only on the fourth consecutive low cycle.
    assign lock_lost = !lock_s && (deb_q == 2'd3);
`else
    // Any single low cycle of lock_s counts as lock loss.
    assign lock_lost = !lock_s;
`endif

    // Next-state, counter, retry and output decode.
    always_comb begin
        // NOTE: every signal written here gets a default first, so that no
        // path through the case statements can leave a latch behind.
        state_d      = state_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        domain_rst_d = domain_rst_q;

        if (sw_reset_i) begin
            // A user reset beats every other transition. While it is held,
            // the block stays in RESET_PLL with the counter held at 0.
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == PLL_RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    // If lock arrives in the same cycle as the timeout, lock wins.
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = ST_RESET_PLL;
                        cnt_d   = '0;
                        if (retry_q != 8'hFF) begin
                            retry_d = retry_q + 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_STABLE: begin
                    // Losing lock here restarts the lock window. It does not count as a retry.
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    if (lock_lost) begin
                        state_d = ST_RESET_PLL;
                        cnt_d   = '0;
                    end else begin
                        // Domain k comes out of reset at stagger slot k. Bits already released stay low.
                        for (int k = 0; k < int'(NUM_DOMAINS); k++) begin
                            if (cnt_q == CNT_W'(k * int'(STAGGER_CYCLES))) begin
                                domain_rst_d[k] = 1'b0;
                            end
                        end
                        if (cnt_q == RELEASE_LAST) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (lock_lost) begin
                        state_d = ST_RESET_PLL;
                        cnt_d   = '0;
                    end else begin
                        domain_rst_d = '0;
                    end
                end

                default: begin
                    state_d = ST_RESET_PLL;
                    cnt_d   = '0;
                end
            endcase
        end

        // Registered outputs are derived from the state being entered, so
        // they change on the same edge as the state does.
        pll_rst_d = (state_d == ST_RESET_PLL);
        if (state_d != ST_RELEASE && state_d != ST_RUN) begin
            domain_rst_d = '1;
        end
        // ready_o rises one cycle after RUN is entered, once every domain is out of reset.
        ready_d = (state_q == ST_RUN) && (state_d == ST_RUN);
    end

    // FSM state, shared counter, retry counter and output registers.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RESET_PLL;
            cnt_q        <= '0;
            retry_q      <= '0;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= '1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            pll_rst_q    <= pll_rst_d;
            domain_rst_q <= domain_rst_d;
            ready_q      <= ready_d;
        end
    end

    assign pll_rst_o     = pll_rst_q;
    assign domain_rst_o  = domain_rst_q;
    assign ready_o       = ready_q;
    assign retry_count_o = retry_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed bench for pll_reset_sequencer. It uses small parameter values so
// the full sequence finishes quickly. Inputs are driven and outputs sampled
// on the falling edge of refclk. If PLL_SEQ_LOCK_DEBOUNCE_EN is defined, the
// lock-loss-in-RUN expectations follow the debounced behaviour.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int unsigned PRC = 4;
    localparam int unsigned LSC = 8;
    localparam int unsigned LTC = 32;
    localparam int unsigned ND  = 4;
    localparam int unsigned SC  = 2;
    localparam int unsigned RETRY_PERIOD = PRC + LTC;

    logic          refclk;
    logic          rst;
    logic          pll_locked_i;
    logic          sw_reset_i;
    logic          pll_rst_o;
    logic [ND-1:0] domain_rst_o;
    logic          ready_o;
    logic [7:0]    retry_count_o;
    logic [2:0]    state_o;

    int n_checks = 0;
    int n_fail   = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (PRC),
        .LOCK_STABLE_CYCLES (LSC),
        .LOCK_TIMEOUT_CYCLES(LTC),
        .NUM_DOMAINS        (ND),
        .STAGGER_CYCLES     (SC)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked_i (pll_locked_i),
        .sw_reset_i   (sw_reset_i),
        .pll_rst_o    (pll_rst_o),
        .domain_rst_o (domain_rst_o),
        .ready_o      (ready_o),
        .retry_count_o(retry_count_o),
        .state_o      (state_o)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge refclk);
    endtask

    // Stops a run that hangs.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Expected values for each cycle of the RELEASE window, starting on the first RELEASE cycle.
    logic [3:0] exp_dom   [9] = '{4'hF, 4'hE, 4'hE, 4'hC, 4'hC, 4'h8, 4'h8, 4'h0, 4'h0};
    logic [2:0] exp_state [9] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4};
    logic       exp_ready [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int cnt;
        rst          = 1'b1;
        pll_locked_i = 1'b0;
        sw_reset_i   = 1'b0;
        step(2);

        // Reset state
        check("rst_pll_rst", 32'(pll_rst_o), 32'd1);
        check("rst_domain", 32'(domain_rst_o), 32'hF);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_retry", 32'(retry_count_o), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);

        // 1. Nominal bring-up
        rst = 1'b0;
        cnt = 0;
        while (pll_rst_o && cnt < 50) begin
            step(1);
            cnt++;
        end
        check("pll_rst_width", 32'(cnt), 32'(PRC));
        check("wait_lock_entered", 32'(state_o), 32'd1);
        step(9);
        pll_locked_i = 1'b1;
        step(2);
        check("still_wait_lock", 32'(state_o), 32'd1);
        step(1);
        check("stable_entered", 32'(state_o), 32'd2);
        cnt = 0;
        while (state_o == 3'd2 && cnt < 50) begin
            step(1);
            cnt++;
        end
        check("stable_len", 32'(cnt), 32'(LSC));
        for (int i = 0; i < 9; i++) begin
            check($sformatf("rel_dom_%0d", i), 32'(domain_rst_o), 32'(exp_dom[i]));
            check($sformatf("rel_state_%0d", i), 32'(state_o), 32'(exp_state[i]));
            check($sformatf("rel_ready_%0d", i), 32'(ready_o), 32'(exp_ready[i]));
            if (i < 8) step(1);
        end

        // 4. Lock loss in RUN
        step(2);
        check("run_ready", 32'(ready_o), 32'd1);
        check("run_pll_rst", 32'(pll_rst_o), 32'd0);
`ifdef PLL_SEQ_LOCK_DEBOUNCE_EN
        pll_locked_i = 1'b0;
        step(3);
        pll_locked_i = 1'b1;
        step(8);
        check("glitch_ready_held", 32'(ready_o), 32'd1);
        check("glitch_state_run", 32'(state_o), 32'd4);
`endif
        pll_locked_i = 1'b0;
        cnt = 0;
        while (ready_o && cnt < 20) begin
            step(1);
            cnt++;
        end
`ifdef PLL_SEQ_LOCK_DEBOUNCE_EN
        check("loss_latency", 32'(cnt), 32'd6);
`else
        check("loss_latency", 32'(cnt), 32'd3);
`endif
        check("loss_domain", 32'(domain_rst_o), 32'hF);
        check("loss_pll_rst", 32'(pll_rst_o), 32'd1);
        check("loss_state", 32'(state_o), 32'd0);
        check("loss_retry", 32'(retry_count_o), 32'd0);

        // 2. Timeout retry, with lock held low
        for (int r = 1; r <= 3; r++) begin
            step(PRC - 1);
            check($sformatf("retry%0d_pll_hi", r), 32'(pll_rst_o), 32'd1);
            step(1);
            check($sformatf("retry%0d_pll_lo", r), 32'(pll_rst_o), 32'd0);
            check($sformatf("retry%0d_wait", r), 32'(state_o), 32'd1);
            step(LTC - 1);
            check($sformatf("retry%0d_last_wait", r), 32'(state_o), 32'd1);
            check($sformatf("retry%0d_cnt_before", r), 32'(retry_count_o), 32'(r - 1));
            step(1);
            check($sformatf("retry%0d_state", r), 32'(state_o), 32'd0);
            check($sformatf("retry%0d_pll_rst", r), 32'(pll_rst_o), 32'd1);
            check($sformatf("retry%0d_cnt", r), 32'(retry_count_o), 32'(r));
            check($sformatf("retry%0d_domain", r), 32'(domain_rst_o), 32'hF);
        end

        // 3. Lock drops for one cycle at STABLE cnt=5
        pll_locked_i = 1'b1;
        step(8);
        pll_locked_i = 1'b0;
        step(1);
        pll_locked_i = 1'b1;
        step(1);
        check("drop_stable_cnt5", 32'(state_o), 32'd2);
        step(1);
        check("drop_back_wait", 32'(state_o), 32'd1);
        check("drop_retry_same", 32'(retry_count_o), 32'd3);
        check("drop_domain", 32'(domain_rst_o), 32'hF);
        step(1);
        check("requal_stable", 32'(state_o), 32'd2);
        step(LSC - 1);
        check("requal_last", 32'(state_o), 32'd2);
        check("requal_domain", 32'(domain_rst_o), 32'hF);
        step(1);
        check("requal_release", 32'(state_o), 32'd3);
        check("requal_rel_dom", 32'(domain_rst_o), 32'hF);
        step(1);
        check("requal_bit0", 32'(domain_rst_o), 32'hE);

        // 5. sw_reset in the same cycle as a lock drop, with bit1 already released
        pll_locked_i = 1'b0;
        step(2);
        check("sw_pre_domain", 32'(domain_rst_o), 32'hC);
        check("sw_pre_state", 32'(state_o), 32'd3);
        sw_reset_i = 1'b1;
        step(1);
        sw_reset_i = 1'b0;
        check("sw_state", 32'(state_o), 32'd0);
        check("sw_domain", 32'(domain_rst_o), 32'hF);
        check("sw_pll_rst", 32'(pll_rst_o), 32'd1);
        check("sw_ready", 32'(ready_o), 32'd0);
        check("sw_retry_kept", 32'(retry_count_o), 32'd3);

        // sw_reset held: stays in RESET_PLL with the counter held at 0
        step(2);
        sw_reset_i = 1'b1;
        step(6);
        check("sw_hold_state", 32'(state_o), 32'd0);
        check("sw_hold_pll_rst", 32'(pll_rst_o), 32'd1);
        sw_reset_i   = 1'b0;
        pll_locked_i = 1'b1;
        cnt = 0;
        while (!ready_o && cnt < 60) begin
            step(1);
            cnt++;
        end
        check("rerun_to_ready", 32'(cnt), 32'd21);
        check("rerun_domain", 32'(domain_rst_o), 32'h0);
        check("rerun_state", 32'(state_o), 32'd4);
        check("rerun_retry", 32'(retry_count_o), 32'd3);

        // 6. Async reset between refclk edges while in RUN
        step(2);
        #2;
        rst = 1'b1;
        #1;
        check("async_pll_rst", 32'(pll_rst_o), 32'd1);
        check("async_domain", 32'(domain_rst_o), 32'hF);
        check("async_ready", 32'(ready_o), 32'd0);
        check("async_retry", 32'(retry_count_o), 32'd0);
        check("async_state", 32'(state_o), 32'd0);
        step(1);
        rst          = 1'b0;
        pll_locked_i = 1'b0;

        // Retry counter stops at 255
        step(RETRY_PERIOD * 254);
        check("sat_254", 32'(retry_count_o), 32'd254);
        step(RETRY_PERIOD);
        check("sat_255", 32'(retry_count_o), 32'd255);
        step(RETRY_PERIOD);
        check("sat_hold", 32'(retry_count_o), 32'd255);
        check("sat_state", 32'(state_o), 32'd0);
        check("sat_domain", 32'(domain_rst_o), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
